// File: rtl/overcurrent_retry_ctrl_pkg.sv
// Shared encodings for the overcurrent retry controller: FSM states and fault source bits.
package overcurrent_retry_ctrl_pkg;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] TRIP     = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;
  localparam logic [1:0] LOCKOUT  = 2'd3;

  localparam int unsigned SRC_A   = 0;
  localparam int unsigned SRC_B   = 1;
  localparam int unsigned SRC_BAT = 2;
  localparam int unsigned NUM_SRC = 3;

  typedef logic [NUM_SRC-1:0] src_vec_t;

  // Retry counter saturates rather than wrapping back to zero.
  function automatic logic [2:0] sat_inc3(input logic [2:0] i_val);
    return (i_val == 3'd7) ? i_val : i_val + 3'd1;
  endfunction

endpackage

// File: rtl/overcurrent_retry_ctrl_debounce.sv
// oc_debounce: 2-flop synchronizer followed by a saturating high-time counter.
module oc_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flag,
  output logic o_sync,
  output logic o_qf
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_flag;
      r_sync <= r_meta;
      if (!r_sync) begin
        r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_sync = r_sync;
  assign o_qf   = (r_cnt == CNT_MAX);

endmodule

// File: rtl/overcurrent_retry_ctrl.sv
// Overcurrent supervisor: debounces flags, latches the trip source, cools down, retries, locks out.
module overcurrent_retry_ctrl
  import overcurrent_retry_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned COOLDOWN_CYC = 50000,
  parameter int unsigned CLEAN_CYC    = 500000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       OverA,
  input  logic       OverB,
  input  logic       OverBat,
  input  logic       clear_fault,
  output logic       EnA,
  output logic       EnB,
  output logic [2:0] fault_src,
  output logic [2:0] retry_cnt,
  output logic       lockout,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] COOL_LAST  = CNT_W'(COOLDOWN_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAN_LAST = CNT_W'(CLEAN_CYC - 1);
  localparam logic [2:0]       RETRY_LIM  = 3'(MAX_RETRY);

  src_vec_t w_sync;
  src_vec_t w_qf;
  logic     w_any_sync;

  oc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flag (OverA),
    .o_sync (w_sync[SRC_A]),
    .o_qf   (w_qf[SRC_A])
  );

  oc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flag (OverB),
    .o_sync (w_sync[SRC_B]),
    .o_qf   (w_qf[SRC_B])
  );

  oc_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_bat (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_flag (OverBat),
    .o_sync (w_sync[SRC_BAT]),
    .o_qf   (w_qf[SRC_BAT])
  );

  assign w_any_sync = |w_sync;

  logic [1:0]       r_state;
  logic             r_en;
  src_vec_t         r_fault_src;
  logic [2:0]       r_retry;
  logic [CNT_W-1:0] r_cool;
  logic [CNT_W-1:0] r_clean;

  logic [1:0]       w_state_d;
  src_vec_t         w_src_d;
  logic [2:0]       w_retry_d;
  logic [2:0]       w_retry_inc;
  logic [CNT_W-1:0] w_cool_d;
  logic [CNT_W-1:0] w_clean_d;

  assign w_retry_inc = sat_inc3(r_retry);

  always_comb begin
    w_state_d = r_state;
    w_src_d   = r_fault_src;
    w_retry_d = r_retry;
    w_cool_d  = r_cool;
    w_clean_d = r_clean;
    unique case (r_state)
      RUN: begin
        // A trip outranks a clean-period expiry in the same cycle.
        if (|w_qf) begin
          w_state_d = TRIP;
          w_src_d   = w_qf;
          w_clean_d = '0;
        end else if (w_any_sync) begin
          w_clean_d = '0;
        end else if (r_clean == CLEAN_LAST) begin
          w_clean_d = '0;
          w_retry_d = '0;
        end else begin
          w_clean_d = r_clean + CNT_W'(1);
        end
      end
      TRIP: begin
        w_retry_d = w_retry_inc;
        w_src_d   = r_fault_src | w_qf;
        if (w_retry_inc >= RETRY_LIM) begin
          w_state_d = LOCKOUT;
        end else begin
          w_state_d = COOLDOWN;
          w_cool_d  = COOL_LAST;
        end
      end
      COOLDOWN: begin
        w_src_d = r_fault_src | w_qf;
        if (w_any_sync) begin
          w_cool_d = COOL_LAST;
        end else if (r_cool == '0) begin
          w_state_d = RUN;
          w_clean_d = '0;
        end else begin
          w_cool_d = r_cool - CNT_W'(1);
        end
      end
      LOCKOUT: begin
        // A clear request while a flag is still high is dropped, not queued.
        if (clear_fault && !w_any_sync) begin
          w_state_d = RUN;
          w_retry_d = '0;
          w_src_d   = '0;
          w_clean_d = '0;
        end
      end
      default: w_state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_en        <= 1'b0;
      r_fault_src <= '0;
      r_retry     <= '0;
      r_cool      <= '0;
      r_clean     <= '0;
    end else begin
      r_state     <= w_state_d;
      r_en        <= (w_state_d == RUN);
      r_fault_src <= w_src_d;
      r_retry     <= w_retry_d;
      r_cool      <= w_cool_d;
      r_clean     <= w_clean_d;
    end
  end

  // Raw flag terms give an immediate cut ahead of the synchronized path.
  assign EnA       = r_en & ~OverA & ~OverBat;
  assign EnB       = r_en & ~OverB & ~OverBat;
  assign fault_src = r_fault_src;
  assign retry_cnt = r_retry;
  assign lockout   = (r_state == LOCKOUT);
  assign state     = r_state;

endmodule

// File: tb/tb_overcurrent_retry_ctrl.sv
// Directed self-checking bench for overcurrent_retry_ctrl with short timing parameters.
module tb_overcurrent_retry_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       OverA = 1'b0;
  logic       OverB = 1'b0;
  logic       OverBat = 1'b0;
  logic       clear_fault = 1'b0;
  logic       EnA;
  logic       EnB;
  logic [2:0] fault_src;
  logic [2:0] retry_cnt;
  logic       lockout;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  overcurrent_retry_ctrl #(
    .DEBOUNCE_CYC (4),
    .COOLDOWN_CYC (10),
    .CLEAN_CYC    (20),
    .MAX_RETRY    (2),
    .CNT_W        (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .OverA       (OverA),
    .OverB       (OverB),
    .OverBat     (OverBat),
    .clear_fault (clear_fault),
    .EnA         (EnA),
    .EnB         (EnB),
    .fault_src   (fault_src),
    .retry_cnt   (retry_cnt),
    .lockout     (lockout),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset just released.
  task automatic do_reset();
    OverA = 1'b0; OverB = 1'b0; OverBat = 1'b0; clear_fault = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    total++; if (EnA !== 1'b0) begin bad++; $display("FAIL rst_ena got=%b exp=0", EnA); end
    tick(2);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
    total++; if (retry_cnt !== 3'd0) begin bad++; $display("FAIL rst_retry got=%0d exp=0", retry_cnt); end
    total++; if (fault_src !== 3'd0) begin bad++; $display("FAIL rst_src got=%b exp=000", fault_src); end
    total++; if (lockout !== 1'b0) begin bad++; $display("FAIL rst_lockout got=%b exp=0", lockout); end
    total++; if (EnB !== 1'b0) begin bad++; $display("FAIL rst_enb got=%b exp=0", EnB); end
    rst = 1'b0;
    total++; if (EnA !== 1'b0) begin bad++; $display("FAIL rel_ena_pre got=%b exp=0", EnA); end
    tick(1);
    total++; if ({EnA, EnB} !== 2'b11) begin bad++; $display("FAIL rel_en got=%b exp=11", {EnA, EnB}); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL rel_state got=%0d exp=0", state); end
  endtask

  task automatic test_glitch();
    do_reset();
    tick(1);
    OverA = 1'b1;
    #1;
    total++; if ({EnA, EnB} !== 2'b01) begin bad++; $display("FAIL glitch_cut got=%b exp=01", {EnA, EnB}); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      total++; if (EnA !== 1'b0) begin bad++; $display("FAIL glitch_ena%0d got=%b exp=0", i, EnA); end
    end
    OverA = 1'b0;
    #1;
    total++; if (EnA !== 1'b1) begin bad++; $display("FAIL glitch_ena_back got=%b exp=1", EnA); end
    tick(10);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL glitch_state got=%0d exp=0", state); end
    total++; if (fault_src !== 3'd0) begin bad++; $display("FAIL glitch_src got=%b exp=000", fault_src); end
    total++; if ({EnA, EnB} !== 2'b11) begin bad++; $display("FAIL glitch_en got=%b exp=11", {EnA, EnB}); end
  endtask

  task automatic test_trip_cooldown();
    do_reset();
    tick(1);
    OverA = 1'b1;
    tick(6);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t3_pre_state got=%0d exp=0", state); end
    total++; if (EnB !== 1'b1) begin bad++; $display("FAIL t3_pre_enb got=%b exp=1", EnB); end
    tick(1);
    total++; if (state !== 2'd1) begin bad++; $display("FAIL t3_trip_state got=%0d exp=1", state); end
    total++; if (EnB !== 1'b0) begin bad++; $display("FAIL t3_trip_enb got=%b exp=0", EnB); end
    tick(1);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t3_cool_state got=%0d exp=2", state); end
    total++; if (fault_src !== 3'b001) begin bad++; $display("FAIL t3_src got=%b exp=001", fault_src); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL t3_retry got=%0d exp=1", retry_cnt); end
    tick(2);
    OverA = 1'b0;
    tick(11);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t3_still_cool got=%0d exp=2", state); end
    total++; if (EnB !== 1'b0) begin bad++; $display("FAIL t3_cool_enb got=%b exp=0", EnB); end
    tick(1);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t3_run_state got=%0d exp=0", state); end
    total++; if ({EnA, EnB} !== 2'b11) begin bad++; $display("FAIL t3_run_en got=%b exp=11", {EnA, EnB}); end
  endtask

  task automatic test_lockout();
    do_reset();
    tick(1);
    OverBat = 1'b1;
    tick(8);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t4_cool1 got=%0d exp=2", state); end
    total++; if (fault_src !== 3'b100) begin bad++; $display("FAIL t4_src1 got=%b exp=100", fault_src); end
    tick(2);
    OverBat = 1'b0;
    tick(12);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t4_run1 got=%0d exp=0", state); end
    OverBat = 1'b1;
    tick(8);
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t4_lock_state got=%0d exp=3", state); end
    total++; if (lockout !== 1'b1) begin bad++; $display("FAIL t4_lockout got=%b exp=1", lockout); end
    total++; if (retry_cnt !== 3'd2) begin bad++; $display("FAIL t4_retry got=%0d exp=2", retry_cnt); end
    total++; if (fault_src !== 3'b100) begin bad++; $display("FAIL t4_src2 got=%b exp=100", fault_src); end
    total++; if ({EnA, EnB} !== 2'b00) begin bad++; $display("FAIL t4_lock_en got=%b exp=00", {EnA, EnB}); end
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t4_clr_ignored got=%0d exp=3", state); end
    OverBat = 1'b0;
    tick(3);
    total++; if (lockout !== 1'b1) begin bad++; $display("FAIL t4_not_remembered got=%b exp=1", lockout); end
    total++; if (EnA !== 1'b0) begin bad++; $display("FAIL t4_lock_ena got=%b exp=0", EnA); end
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t4_clr_state got=%0d exp=0", state); end
    total++; if (retry_cnt !== 3'd0) begin bad++; $display("FAIL t4_clr_retry got=%0d exp=0", retry_cnt); end
    total++; if (fault_src !== 3'd0) begin bad++; $display("FAIL t4_clr_src got=%b exp=000", fault_src); end
    total++; if (lockout !== 1'b0) begin bad++; $display("FAIL t4_clr_lockout got=%b exp=0", lockout); end
    total++; if (EnA !== 1'b1) begin bad++; $display("FAIL t4_clr_ena got=%b exp=1", EnA); end
  endtask

  task automatic test_clean_period();
    do_reset();
    tick(1);
    OverA = 1'b1;
    tick(10);
    OverA = 1'b0;
    tick(12);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t5_run got=%0d exp=0", state); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL t5_retry_held got=%0d exp=1", retry_cnt); end
    tick(25);
    total++; if (retry_cnt !== 3'd0) begin bad++; $display("FAIL t5_retry_clean got=%0d exp=0", retry_cnt); end
    OverA = 1'b1;
    tick(8);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t5_cool got=%0d exp=2", state); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL t5_retry2 got=%0d exp=1", retry_cnt); end
    total++; if (lockout !== 1'b0) begin bad++; $display("FAIL t5_lockout got=%b exp=0", lockout); end
    clear_fault = 1'b1;
    tick(1);
    clear_fault = 1'b0;
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t5_clr_noeffect got=%0d exp=2", state); end
    total++; if (retry_cnt !== 3'd1) begin bad++; $display("FAIL t5_clr_retry got=%0d exp=1", retry_cnt); end
    OverA = 1'b0;
    tick(15);
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t5_run2 got=%0d exp=0", state); end
  endtask

  task automatic test_reset_mid_cooldown();
    do_reset();
    tick(1);
    OverA = 1'b1;
    tick(10);
    OverA = 1'b0;
    tick(6);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t6_cool got=%0d exp=2", state); end
    #2 rst = 1'b1;
    #1;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t6_state got=%0d exp=0", state); end
    total++; if ({EnA, EnB} !== 2'b00) begin bad++; $display("FAIL t6_en got=%b exp=00", {EnA, EnB}); end
    total++; if (retry_cnt !== 3'd0) begin bad++; $display("FAIL t6_retry got=%0d exp=0", retry_cnt); end
    total++; if (fault_src !== 3'd0) begin bad++; $display("FAIL t6_src got=%b exp=000", fault_src); end
    total++; if (lockout !== 1'b0) begin bad++; $display("FAIL t6_lockout got=%b exp=0", lockout); end
    tick(3);
    total++; if ({EnA, EnB} !== 2'b00) begin bad++; $display("FAIL t6_hold_en got=%b exp=00", {EnA, EnB}); end
    rst = 1'b0;
    tick(1);
    total++; if ({EnA, EnB} !== 2'b11) begin bad++; $display("FAIL t6_rel_en got=%b exp=11", {EnA, EnB}); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_trip_cooldown();
    test_lockout();
    test_clean_period();
    test_reset_mid_cooldown();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
